// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: arbitrates branch redirects, multi-cycle holds and load-use stalls
// into PC/program-memory controls. Optional STALL_STATS_EN adds saturating stall/flush counters.
module fetch_sequencer #(
    parameter int ADDR_W       = 16,
    parameter int CNT_W        = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hz_req,
    input  logic              mc_req,
    input  logic [CNT_W-1:0]  mc_len,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_target,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              stall,
    output logic              stall_pm,
    output logic              flush,
    output logic              busy
`ifdef STALL_STATS_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       flush_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HOLD     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0]       FLUSH_INIT = 2'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic             stall_q, stall_d;

    logic stall_int;
    logic flush_int;
    logic pc_sel_int;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        stall_int  = 1'b0;
        flush_int  = 1'b0;
        pc_sel_int = 1'b0;

        unique case (state_q)
            RUN: begin
                if (br_req) begin
                    pc_sel_int = 1'b1;
                    fcnt_d     = FLUSH_INIT;
                    state_d    = REDIRECT;
                end else if (mc_req && (mc_len != '0)) begin
                    stall_int = 1'b1;
                    cnt_d     = mc_len;
                    state_d   = HOLD;
                end else if (mc_req || hz_req) begin
                    stall_int = 1'b1;
                end
            end
            HOLD: begin
                // A resolved branch overrides the hold; the held op is squashed with it.
                if (br_req) begin
                    pc_sel_int = 1'b1;
                    cnt_d      = '0;
                    fcnt_d     = FLUSH_INIT;
                    state_d    = REDIRECT;
                end else begin
                    stall_int = 1'b1;
                    cnt_d     = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = RUN;
                    end
                end
            end
            REDIRECT: begin
                // Requests arriving here belong to shadow instructions being flushed.
                flush_int = 1'b1;
                fcnt_d    = fcnt_q - 2'd1;
                if (fcnt_q <= 2'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        stall_d = stall_int;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            stall_q <= stall_d;
        end
    end

    // Outputs are gated by reset so they drop the instant reset asserts, not at the next edge.
    assign pc_mux_sel = reset & pc_sel_int;
    assign jmp_loc    = pc_mux_sel ? br_target : '0;
    assign stall      = reset & stall_int;
    assign stall_pm   = reset & (stall_int | stall_q);
    assign flush      = reset & flush_int;
    assign busy       = reset & (state_q != RUN);

`ifdef STALL_STATS_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_cycles_q, flush_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (stall_int && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (flush_int && (flush_cycles_q != 16'hFFFF)) begin
            flush_cycles_d = flush_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a cycle-level reference model pushes expected outputs,
// a monitor on the falling edge pops and compares them.
module tb_fetch_sequencer;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;
    localparam int FC     = 1;

    logic              clk;
    logic              reset;
    logic              hz_req;
    logic              mc_req;
    logic [CNT_W-1:0]  mc_len;
    logic              br_req;
    logic [ADDR_W-1:0] br_target;
    logic              pc_mux_sel;
    logic [ADDR_W-1:0] jmp_loc;
    logic              stall;
    logic              stall_pm;
    logic              flush;
    logic              busy;
`ifdef STALL_STATS_EN
    logic [15:0]       stall_cycles;
    logic [15:0]       flush_cycles;
`endif

    fetch_sequencer #(
        .ADDR_W      (ADDR_W),
        .CNT_W       (CNT_W),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hz_req    (hz_req),
        .mc_req    (mc_req),
        .mc_len    (mc_len),
        .br_req    (br_req),
        .br_target (br_target),
        .pc_mux_sel(pc_mux_sel),
        .jmp_loc   (jmp_loc),
        .stall     (stall),
        .stall_pm  (stall_pm),
        .flush     (flush),
        .busy      (busy)
`ifdef STALL_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_cycles(flush_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              pc;
        logic [ADDR_W-1:0] jl;
        logic              st;
        logic              stpm;
        logic              fl;
        logic              bsy;
`ifdef STALL_STATS_EN
        logic [15:0]       sc;
        logic [15:0]       fcn;
`endif
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Reference model: remaining hold / flush cycles as plain integers.
    int   hold_left  = 0;
    int   flush_left = 0;
    logic prev_stall = 1'b0;
`ifdef STALL_STATS_EN
    int   m_sc = 0;
    int   m_fc = 0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hold_left  = 0;
        flush_left = 0;
        prev_stall = 1'b0;
`ifdef STALL_STATS_EN
        m_sc = 0;
        m_fc = 0;
`endif
    endtask

    task automatic drive_cycle(input logic hz, input logic mc, input logic [CNT_W-1:0] len,
                               input logic br, input logic [ADDR_W-1:0] tgt);
        exp_t e;
        @(posedge clk);
        #1;
        hz_req    = hz;
        mc_req    = mc;
        mc_len    = len;
        br_req    = br;
        br_target = tgt;

        e.pc  = 1'b0;
        e.jl  = '0;
        e.st  = 1'b0;
        e.fl  = 1'b0;
        e.bsy = (hold_left > 0) || (flush_left > 0);
`ifdef STALL_STATS_EN
        e.sc  = 16'(m_sc);
        e.fcn = 16'(m_fc);
`endif
        if (flush_left > 0) begin
            e.fl = 1'b1;
            flush_left--;
        end else if (br) begin
            e.pc       = 1'b1;
            e.jl       = tgt;
            hold_left  = 0;
            flush_left = FC;
        end else if (hold_left > 0) begin
            e.st = 1'b1;
            hold_left--;
        end else if (mc && (len != 0)) begin
            e.st      = 1'b1;
            hold_left = int'(len);
        end else if (mc || hz) begin
            e.st = 1'b1;
        end
        e.stpm     = e.st | prev_stall;
        prev_stall = e.st;
`ifdef STALL_STATS_EN
        if (e.st && m_sc < 65535) m_sc++;
        if (e.fl && m_fc < 65535) m_fc++;
`endif
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc_mux_sel"}, 32'(pc_mux_sel), 32'd0);
        check({tag, "_jmp_loc"},    32'(jmp_loc),    32'd0);
        check({tag, "_stall"},      32'(stall),      32'd0);
        check({tag, "_stall_pm"},   32'(stall_pm),   32'd0);
        check({tag, "_flush"},      32'(flush),      32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    // Monitor: outputs are valid every cycle outside reset; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pc_mux_sel", 32'(pc_mux_sel), 32'(e.pc));
                    check("jmp_loc",    32'(jmp_loc),    32'(e.jl));
                    check("stall",      32'(stall),      32'(e.st));
                    check("stall_pm",   32'(stall_pm),   32'(e.stpm));
                    check("flush",      32'(flush),      32'(e.fl));
                    check("busy",       32'(busy),       32'(e.bsy));
`ifdef STALL_STATS_EN
                    check("stall_cycles", 32'(stall_cycles), 32'(e.sc));
                    check("flush_cycles", 32'(flush_cycles), 32'(e.fcn));
`endif
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        hz_req    = 1'b1;
        mc_req    = 1'b1;
        mc_len    = 4'd3;
        br_req    = 1'b1;
        br_target = 16'hBEEF;
        #3;
        check_all_zero("reset_init");
        hz_req    = 1'b0;
        mc_req    = 1'b0;
        mc_len    = '0;
        br_req    = 1'b0;
        br_target = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        idle(2);

        // Single load-use stall.
        drive_cycle(1'b1, 1'b0, '0, 1'b0, '0);
        idle(3);
        // Multi-cycle op, mc_len=3, and the mc_len=0 degenerate case.
        drive_cycle(1'b0, 1'b1, 4'd3, 1'b0, '0);
        idle(6);
        drive_cycle(1'b0, 1'b1, 4'd0, 1'b0, '0);
        idle(2);
        // Branch from RUN.
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 16'h0040);
        idle(3);
        // Branch in the 2nd HOLD cycle of an mc_len=5 op.
        drive_cycle(1'b0, 1'b1, 4'd5, 1'b0, '0);
        drive_cycle(1'b1, 1'b1, 4'd2, 1'b0, '0);
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 16'h0100);
        idle(4);
        // Requests during REDIRECT are ignored.
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 16'h0123);
        drive_cycle(1'b1, 1'b1, 4'd7, 1'b1, 16'h0200);
        idle(3);
        // Boundary: largest mc_len.
        drive_cycle(1'b0, 1'b1, 4'd15, 1'b0, '0);
        idle(18);

        // Asynchronous reset during a long hold.
        drive_cycle(1'b0, 1'b1, 4'd10, 1'b0, '0);
        idle(2);
        @(posedge clk);
        #1;
        mon_en    = 1'b0;
        hz_req    = 1'b1;
        mc_req    = 1'b1;
        mc_len    = 4'd9;
        br_req    = 1'b1;
        br_target = 16'hAAAA;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("reset_hold");
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        hz_req    = 1'b0;
        mc_req    = 1'b0;
        mc_len    = '0;
        br_req    = 1'b0;
        br_target = '0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle($urandom_range(99, 0) < 20,
                        $urandom_range(99, 0) < 10,
                        CNT_W'($urandom_range(15, 0)),
                        $urandom_range(99, 0) < 8,
                        ADDR_W'($urandom));
        end
        idle(20);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
